// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the 7-segment scan driver
package display_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   localparam int DEFAULT_BLANK_CYCLES = 16;

   // Active-high {g,f,e,d,c,b,a}; entry 15 (F) is listed first
   localparam logic [15:0][6:0] SEG7_HEX = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - hex nibble to active-high segment pattern
// Blank forces every segment off regardless of the value.
module seg7_hex_decoder
   import display_pkg::*;
(
   input  logic [3:0] value_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   assign seg_o = blank_i ? 7'h00 : SEG7_HEX[value_i];

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - time-multiplexed 7-segment scan driver
// Advances one digit per scan_in edge with a blanking gap; shadow digits reload at frame boundaries.
module display_scan_driver
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    scan_in,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    blank_lz,
   input  logic                    load,
   output logic                    load_ack,
   output logic                    frame_done,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              seg,
   output logic                    seg_dp
);

   localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int PTR_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};

   logic s0_q, s1_q, s2_q;
   logic step;

   scan_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [NUM_DIGITS-1:0][3:0] shadow_dig_q, shadow_dig_d;
   logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
   logic load_pending_q, load_pending_d;
   logic boundary, serve;

   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [6:0] seg_q, seg_d;
   logic seg_dp_q, seg_dp_d;
   logic load_ack_q, frame_done_q;

   logic [NUM_DIGITS-1:0] zero_from;
   logic zero_acc;
   logic lz_blank;
   logic [6:0] dec_seg;
   logic [NUM_DIGITS-1:0] anode_ah;

   assign step = s1_q ^ s2_q;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      ptr_d          = ptr_q;
      shadow_dig_d   = shadow_dig_q;
      shadow_dp_d    = shadow_dp_q;
      load_pending_d = load_pending_q;
      boundary       = 1'b0;
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == CNT_MAX) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SHOW: begin
            if (step) begin
               state_d  = ST_BLANK;
               boundary = (ptr_q == PTR_MAX);
               ptr_d    = boundary ? '0 : ptr_q + PTR_W'(1);
            end
         end
         default: state_d = ST_BLANK;
      endcase

      // Digits are sampled in the boundary cycle itself, not when load was raised
      serve = boundary && (load_pending_q || load);
      if (serve) begin
         shadow_dig_d = digits;
         shadow_dp_d  = dp;
      end
      if (boundary) begin
         load_pending_d = 1'b0;
      end else if (load) begin
         load_pending_d = 1'b1;
      end
   end

   // zero_from[i] is set when shadow digits i..NUM_DIGITS-1 are all zero
   always_comb begin
      zero_from = '0;
      zero_acc  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_acc     = zero_acc & (shadow_dig_d[i] == 4'd0);
         zero_from[i] = zero_acc;
      end
   end

   assign lz_blank = blank_lz && (ptr_d != '0) && zero_from[ptr_d];

   seg7_hex_decoder u_dec (
      .value_i (shadow_dig_d[ptr_d]),
      .blank_i (lz_blank),
      .seg_o   (dec_seg)
   );

   always_comb begin
      anode_ah = '0;
      anode_d  = ANODE_OFF;
      seg_d    = SEG_OFF;
      seg_dp_d = ACTIVE_LOW;
      if (state_d == ST_SHOW) begin
         anode_ah[ptr_d] = 1'b1;
         anode_d  = ANODE_OFF ^ anode_ah;
         seg_d    = SEG_OFF ^ dec_seg;
         seg_dp_d = ACTIVE_LOW ^ shadow_dp_d[ptr_d];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_q           <= 1'b0;
         s1_q           <= 1'b0;
         s2_q           <= 1'b0;
         state_q        <= ST_BLANK;
         cnt_q          <= '0;
         ptr_q          <= '0;
         shadow_dig_q   <= '0;
         shadow_dp_q    <= '0;
         load_pending_q <= 1'b0;
         anode_q        <= ANODE_OFF;
         seg_q          <= SEG_OFF;
         seg_dp_q       <= ACTIVE_LOW;
         load_ack_q     <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         s0_q           <= scan_in;
         s1_q           <= s0_q;
         s2_q           <= s1_q;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ptr_q          <= ptr_d;
         shadow_dig_q   <= shadow_dig_d;
         shadow_dp_q    <= shadow_dp_d;
         load_pending_q <= load_pending_d;
         anode_q        <= anode_d;
         seg_q          <= seg_d;
         seg_dp_q       <= seg_dp_d;
         load_ack_q     <= serve;
         frame_done_q   <= boundary;
      end
   end

   assign anode      = anode_q;
   assign seg        = seg_q;
   assign seg_dp     = seg_dp_q;
   assign load_ack   = load_ack_q;
   assign frame_done = frame_done_q;

endmodule
